// File: rtl/rs_issue_arbiter.sv
// Issue stage for several reservation stations sharing one execution unit.
// Picks the oldest request by distance from the head ID, with a starvation override.
module rs_issue_arbiter #(
  parameter int unsigned REQUESTERS   = 3,
  parameter int unsigned RS_ID_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CTRL_WIDTH   = 40,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [RS_ID_WIDTH-1:0]                 head_rs_id,
  input  logic [REQUESTERS-1:0]                  req_valid,
  output logic [REQUESTERS-1:0]                  req_ready,
  input  logic [REQUESTERS-1:0][RS_ID_WIDTH-1:0] req_rs_id,
  input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]  req_op,
  input  logic [REQUESTERS-1:0][CTRL_WIDTH-1:0]  req_control,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [RS_ID_WIDTH-1:0]                 out_rs_id,
  output logic [DATA_WIDTH-1:0]                  out_op,
  output logic [CTRL_WIDTH-1:0]                  out_control,
  output logic [$clog2(REQUESTERS)-1:0]          out_src
);

  localparam int unsigned SRC_W = $clog2(REQUESTERS);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic                                   out_valid_q, out_valid_d;
  logic [RS_ID_WIDTH-1:0]                 out_rs_id_q, out_rs_id_d;
  logic [DATA_WIDTH-1:0]                  out_op_q, out_op_d;
  logic [CTRL_WIDTH-1:0]                  out_control_q, out_control_d;
  logic [SRC_W-1:0]                       out_src_q, out_src_d;
  logic [REQUESTERS-1:0][CNT_W-1:0]       cnt_q, cnt_d;

  logic [REQUESTERS-1:0][RS_ID_WIDTH-1:0] age;
  logic                                   starved_any;
  logic [SRC_W-1:0]                       starved_idx;
  logic                                   oldest_any;
  logic [SRC_W-1:0]                       oldest_idx;
  logic [RS_ID_WIDTH-1:0]                 oldest_age;
  logic [SRC_W-1:0]                       grant_idx;
  logic                                   adv;
  logic                                   xfer;

  // Grant selection: starved requester first, otherwise smallest wrap-safe age
  always_comb begin
    starved_any = 1'b0;
    starved_idx = '0;
    oldest_any  = 1'b0;
    oldest_idx  = '0;
    oldest_age  = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      age[i] = req_rs_id[i] - head_rs_id;
      if (req_valid[i] && !starved_any && cnt_q[i] == CNT_W'(STARVE_LIMIT)) begin
        starved_any = 1'b1;
        starved_idx = SRC_W'(i);
      end
      // strict less-than keeps the lowest index on equal ages
      if (req_valid[i] && (!oldest_any || age[i] < oldest_age)) begin
        oldest_any = 1'b1;
        oldest_idx = SRC_W'(i);
        oldest_age = age[i];
      end
    end
    grant_idx = starved_any ? starved_idx : oldest_idx;
  end

  assign adv  = ~out_valid_q | out_ready;
  assign xfer = oldest_any & adv & ~flush & ~rst;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  // Output register next state
  always_comb begin
    out_valid_d   = out_valid_q;
    out_rs_id_d   = out_rs_id_q;
    out_op_d      = out_op_q;
    out_control_d = out_control_q;
    out_src_d     = out_src_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (adv) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_rs_id_d   = req_rs_id[grant_idx];
        out_op_d      = req_op[grant_idx];
        out_control_d = req_control[grant_idx];
        out_src_d     = grant_idx;
      end
    end
  end

  // Starvation counters: clear on win or idle, saturate while losing
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (flush || !req_valid[i]) begin
        cnt_d[i] = '0;
      end else if (xfer && grant_idx == SRC_W'(i)) begin
        cnt_d[i] = '0;
      end else if (xfer && cnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_rs_id_q   <= '0;
      out_op_q      <= '0;
      out_control_q <= '0;
      out_src_q     <= '0;
      cnt_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_rs_id_q   <= out_rs_id_d;
      out_op_q      <= out_op_d;
      out_control_q <= out_control_d;
      out_src_q     <= out_src_d;
      cnt_q         <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs_id   = out_rs_id_q;
  assign out_op      = out_op_q;
  assign out_control = out_control_q;
  assign out_src     = out_src_q;

endmodule

// File: doc/rs_issue_arbiter.md
Name: rs_issue_arbiter

Overview:
- Registered issue stage that shares one execution unit among REQUESTERS reservation stations.
- Each cycle it selects the oldest valid request, measured as wrap-safe distance of rs_id from the in-flight head ID.
- A per-requester starvation counter bounds waiting time.
- It sits between the reservation stations and a unit such as sys_unit, and presents a single registered ready/valid stream.

Parameters:
- REQUESTERS, 3, number of requesting reservation stations (2..8).
- RS_ID_WIDTH, 5, width of reservation-station IDs.
- DATA_WIDTH, 32, operand width.
- CTRL_WIDTH, 40, width of the packed control word passed through untouched.
- STARVE_LIMIT, 8, count of lost arbitrations that forces priority (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- head_rs_id  in  RS_ID_WIDTH  ID of the oldest uncommitted instruction; the age reference.
- req_valid  in  REQUESTERS  per-requester valid.
- req_ready  out  REQUESTERS  per-requester ready; one-hot or zero.
- req_rs_id  in  REQUESTERS x RS_ID_WIDTH  per-requester RS ID.
- req_op  in  REQUESTERS x DATA_WIDTH  per-requester operand.
- req_control  in  REQUESTERS x CTRL_WIDTH  per-requester control word.
- out_valid  out  1  registered issue valid.
- out_ready  in  1  unit accepts the issued item.
- out_rs_id  out  RS_ID_WIDTH  issued RS ID.
- out_op  out  DATA_WIDTH  issued operand.
- out_control  out  CTRL_WIDTH  issued control word.
- out_src  out  $clog2(REQUESTERS)  index of the requester that was issued.

Behaviour:
- **Reset:** on rst, out_valid=0; out_rs_id, out_op, out_control and out_src are all 0; every starvation counter is 0. req_ready is 0 while rst is high.
- **Age:** age_i = (req_rs_id[i] - head_rs_id) mod 2^RS_ID_WIDTH, computed unsigned at RS_ID_WIDTH bits. Smaller age means older. Wrap-around is therefore handled; a raw ID compare is forbidden.
- **Selection (combinational):**
  - If any valid requester has counter == STARVE_LIMIT, the grant goes to the lowest-index such requester.
  - Otherwise the grant goes to the valid requester with the minimum age.
  - Equal ages resolve to the lowest index.
  - No valid requester means no grant.
- **Advance condition:** adv = ~out_valid | out_ready.
- **Handshake:**
  - req_ready[g] = grant[g] & adv & ~flush. All other bits are 0.
  - A transfer happens when req_valid[g] & req_ready[g] are both high.
  - On a transfer, the output register loads the requester's rs_id, op and control, sets out_src=g and sets out_valid=1 on the next edge.
  - If adv=1 and nothing is transferred, out_valid goes to 0 on the next edge.
  - If adv=0, all output registers hold.
  - Output latency is exactly 1 cycle from acceptance.
  - The output must not change while out_valid=1 and out_ready=0.
- **Throughput:** one issue per cycle while out_ready stays high.
- **Starvation counters (one per requester, width $clog2(STARVE_LIMIT+1)):**
  - Clear to 0 when the requester transfers, or when it is not valid.
  - Increment, saturating at STARVE_LIMIT, when it is valid, adv=1, and another requester transfers.
  - Hold otherwise, including during backpressure.
- **Flush:**
  - On the next edge out_valid=0 and all counters clear.
  - No transfer occurs during the flush cycle.
  - Flush has priority over out_ready and over new requests.
- **Simultaneous events:**
  - If out_ready and a new grant occur in the same cycle, the issued item retires and the new item loads on the same edge; no bubble.
  - A requester dropping req_valid without a transfer is legal; it is simply not granted.
- **Reset mid-operation:** the in-flight output is discarded immediately (asynchronous); no transfer is reported.

Test Plan:
- **Basic issue:** head=0, only req1 valid with rs_id=3, op=0xDEADBEEF, out_ready=1 -> req_ready=3'b010 in cycle 0; cycle 1 shows out_valid=1, out_rs_id=3, out_op=0xDEADBEEF, out_src=1.
- **Wrap-around age:** head=30, req0 rs_id=2, req1 rs_id=31, req2 rs_id=30 all valid -> issue order over three cycles is rs_id 30, 31, 2 (src 2, 1, 0).
- **Backpressure:** out_valid=1 with rs_id=5 and out_ready=0 for 4 cycles while req0 is valid -> req_ready=0 and outputs stable throughout; on the out_ready=1 cycle req0 is accepted and appears with no bubble.
- **Starvation:** STARVE_LIMIT=2, head=0, req2 held valid at rs_id=20 while req0 keeps presenting younger-than-head IDs 1, 2, 3 -> req2 is granted on its 3rd arbitration (counter==2) even though req0 is older.
- **Tie:** req0 and req2 both have rs_id=7 -> req0 is granted first.
- **Flush/reset:** out_valid=1 with flush=1 and req1 valid -> req_ready=0, next cycle out_valid=0 and counters=0. Asserting rst asynchronously mid-transfer drops out_valid at once, and all outputs read 0.
